mm_ss_countdown_timer: RTL and testbench

//   Cook-time countdown for the microwave: holds a M:SS value (minutes units, seconds tens/units, BCD),

---
 rtl/mm_ss_countdown_timer_if.sv | 49 ++++
 rtl/mm_ss_countdown_timer.sv | 230 +++++++++++++++++++++++
 tb/tb_mm_ss_countdown_timer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_ss_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// mm_ss_countdown_timer_if
//   Control/data bundle between the keypad/setting logic (master) and the
//   M:SS cook-time countdown timer (slave).
//   Signals:
//     load, load_min_units[3:0], load_sec_tens[2:0], load_sec_units[3:0]
//                         master -> slave  digit load request and values
//     start, pause, clear master -> slave  run control
//     add30               master -> slave  +30 s request (only with ADD30_EN)
//     minutes_units[3:0], seconds_tens[2:0], seconds_units[3:0]
//                         slave -> master  current digits
//     running, done       slave -> master  status / completion pulse
//   Optional feature macro: ADD30_EN
// ---------------------------------------------------------------------------
interface mm_ss_countdown_timer_if;
  logic       load;
  logic [3:0] load_min_units;
  logic [2:0] load_sec_tens;
  logic [3:0] load_sec_units;
  logic       start;
  logic       pause;
  logic       clear;
`ifdef ADD30_EN
  logic       add30;
`endif
  logic [3:0] minutes_units;
  logic [2:0] seconds_tens;
  logic [3:0] seconds_units;
  logic       running;
  logic       done;

  modport master (
    output load, load_min_units, load_sec_tens, load_sec_units,
    output start, pause, clear,
`ifdef ADD30_EN
    output add30,
`endif
    input  minutes_units, seconds_tens, seconds_units, running, done
  );

  modport slave (
    input  load, load_min_units, load_sec_tens, load_sec_units,
    input  start, pause, clear,
`ifdef ADD30_EN
    input  add30,
`endif
    output minutes_units, seconds_tens, seconds_units, running, done
  );
endinterface

// File: rtl/mm_ss_countdown_timer.sv
// ---------------------------------------------------------------------------
// mm_ss_countdown_timer
//   Microwave cook-time countdown. Holds M:SS in BCD (minutes units, seconds
//   tens, seconds units), loaded from the keypad logic, and counts it down
//   once per second to 0:00 with run/pause/clear control and a one-cycle
//   done pulse when the count expires.
//   Parameters:
//     TICK_DIV  CLK cycles per one-second decrement (>= 1)
//     MAX_MIN   largest minutes value accepted on load (0..9)
//   Ports:
//     CLK      in  rising-edge clock
//     Reset    in  synchronous active-high reset
//     io_bus   mm_ss_countdown_timer_if.slave (load/start/pause/clear in,
//              digits/running/done out; all outputs registered)
//   Optional feature macro: ADD30_EN (adds the add30 request: 0:30 + RUN
//   from IDLE, +30 s saturating at MAX_MIN:59 in RUN/PAUSE)
//
//   state   | meaning
//   S_IDLE  | stopped, digits loadable, start needs a nonzero value
//   S_RUN   | counting down, prescaler advancing
//   S_PAUSE | frozen, digits and prescaler held, digits loadable
// ---------------------------------------------------------------------------
module mm_ss_countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int MAX_MIN  = 9
) (
  input  logic                      CLK,
  input  logic                      Reset,
  mm_ss_countdown_timer_if.slave    io_bus
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      MAX_MU   = 4'(MAX_MIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_mu, w_mu_nxt;
  logic [2:0]    r_st, w_st_nxt;
  logic [3:0]    r_su, w_su_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          r_running;
  logic          r_done, w_done_nxt;

  // Saturated load values
  logic [3:0] w_ld_mu;
  logic [2:0] w_ld_st;
  logic [3:0] w_ld_su;

  assign w_ld_mu = (io_bus.load_min_units > MAX_MU) ? MAX_MU : io_bus.load_min_units;
  assign w_ld_st = (io_bus.load_sec_tens  > 3'd5)   ? 3'd5   : io_bus.load_sec_tens;
  assign w_ld_su = (io_bus.load_sec_units > 4'd9)   ? 4'd9   : io_bus.load_sec_units;

  logic w_is_zero;
  assign w_is_zero = (r_mu == 4'd0) && (r_st == 3'd0) && (r_su == 4'd0);

  // One-second BCD decrement; the mu != 0 guard keeps 0:00 from wrapping.
  logic [3:0] w_dec_mu;
  logic [2:0] w_dec_st;
  logic [3:0] w_dec_su;
  logic       w_dec_zero;

  always_comb begin
    w_dec_mu = r_mu;
    w_dec_st = r_st;
    w_dec_su = r_su;
    if (r_su != 4'd0) begin
      w_dec_su = r_su - 4'd1;
    end else if (r_st != 3'd0) begin
      w_dec_st = r_st - 3'd1;
      w_dec_su = 4'd9;
    end else if (r_mu != 4'd0) begin
      w_dec_mu = r_mu - 4'd1;
      w_dec_st = 3'd5;
      w_dec_su = 4'd9;
    end
  end

  assign w_dec_zero = (w_dec_mu == 4'd0) && (w_dec_st == 3'd0) && (w_dec_su == 4'd0);

`ifdef ADD30_EN
  // +30 s: seconds units untouched, tens +3 with carry into minutes,
  // clamped to MAX_MIN:59 when the carry would overflow the minutes digit.
  logic [3:0] w_add_mu;
  logic [2:0] w_add_st;
  logic [3:0] w_add_su;
  logic [3:0] w_st_sum;

  assign w_st_sum = {1'b0, r_st} + 4'd3;

  always_comb begin
    w_add_mu = r_mu;
    w_add_st = w_st_sum[2:0];
    w_add_su = r_su;
    if (w_st_sum > 4'd5) begin
      if (r_mu >= MAX_MU) begin
        w_add_mu = MAX_MU;
        w_add_st = 3'd5;
        w_add_su = 4'd9;
      end else begin
        w_add_mu = r_mu + 4'd1;
        w_add_st = 3'(w_st_sum - 4'd6);
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_mu      <= 4'd0;
      r_st      <= 3'd0;
      r_su      <= 4'd0;
      r_pre     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mu      <= w_mu_nxt;
      r_st      <= w_st_nxt;
      r_su      <= w_su_nxt;
      r_pre     <= w_pre_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= w_done_nxt;
    end
  end

  // Priority: clear > load > add30 > start > pause; the tick is background
  // work done only in RUN when no control request claims the cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mu_nxt    = r_mu;
    w_st_nxt    = r_st;
    w_su_nxt    = r_su;
    w_pre_nxt   = r_pre;
    w_done_nxt  = 1'b0;

    if (io_bus.clear) begin
      w_state_nxt = S_IDLE;
      w_mu_nxt    = 4'd0;
      w_st_nxt    = 3'd0;
      w_su_nxt    = 4'd0;
      w_pre_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.load) begin
            w_mu_nxt  = w_ld_mu;
            w_st_nxt  = w_ld_st;
            w_su_nxt  = w_ld_su;
            w_pre_nxt = '0;
          end else
`ifdef ADD30_EN
          if (io_bus.add30) begin
            w_mu_nxt    = 4'd0;
            w_st_nxt    = 3'd3;
            w_su_nxt    = 4'd0;
            w_pre_nxt   = '0;
            w_state_nxt = S_RUN;
          end else
`endif
          if (io_bus.start && !w_is_zero) begin
            w_pre_nxt   = '0;
            w_state_nxt = S_RUN;
          end
        end

        S_RUN: begin
`ifdef ADD30_EN
          if (io_bus.add30) begin
            w_mu_nxt = w_add_mu;
            w_st_nxt = w_add_st;
            w_su_nxt = w_add_su;
          end else
`endif
          if (io_bus.pause) begin
            w_state_nxt = S_PAUSE;
          end else if (r_pre == PRE_LAST) begin
            w_pre_nxt = '0;
            w_mu_nxt  = w_dec_mu;
            w_st_nxt  = w_dec_st;
            w_su_nxt  = w_dec_su;
            if (w_dec_zero) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_pre_nxt = r_pre + PW'(1);
          end
        end

        S_PAUSE: begin
          if (io_bus.load) begin
            w_mu_nxt  = w_ld_mu;
            w_st_nxt  = w_ld_st;
            w_su_nxt  = w_ld_su;
            w_pre_nxt = '0;
          end else
`ifdef ADD30_EN
          if (io_bus.add30) begin
            w_mu_nxt = w_add_mu;
            w_st_nxt = w_add_st;
            w_su_nxt = w_add_su;
          end else
`endif
          if (io_bus.start) begin
            // Resuming keeps the held prescaler phase; 0:00 just parks in IDLE.
            w_state_nxt = w_is_zero ? S_IDLE : S_RUN;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.minutes_units = r_mu;
  assign io_bus.seconds_tens  = r_st;
  assign io_bus.seconds_units = r_su;
  assign io_bus.running       = r_running;
  assign io_bus.done          = r_done;

endmodule

// File: tb/tb_mm_ss_countdown_timer.sv
module tb_mm_ss_countdown_timer;
  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_errors;

  mm_ss_countdown_timer_if ifs ();
  mm_ss_countdown_timer_if ifs10 ();

  mm_ss_countdown_timer #(.TICK_DIV(1), .MAX_MIN(9)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .io_bus (ifs)
  );

  mm_ss_countdown_timer #(.TICK_DIV(10), .MAX_MIN(9)) dut10 (
    .CLK    (CLK),
    .Reset  (Reset),
    .io_bus (ifs10)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [10:0] val(input int mu, input int st, input int su);
    return {4'(mu), 3'(st), 4'(su)};
  endfunction

  function automatic logic [10:0] sec2val(input int s);
    return {4'(s / 60), 3'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] d1();
    return {ifs.minutes_units, ifs.seconds_tens, ifs.seconds_units};
  endfunction

  function automatic logic [10:0] d10();
    return {ifs10.minutes_units, ifs10.seconds_tens, ifs10.seconds_units};
  endfunction

  task automatic do_load(input int mu, input int st, input int su);
    ifs.load = 1'b1;
    ifs.load_min_units = 4'(mu);
    ifs.load_sec_tens  = 3'(st);
    ifs.load_sec_units = 4'(su);
    tick();
    ifs.load = 1'b0;
  endtask

  task automatic pulse_start();
    ifs.start = 1'b1;
    tick();
    ifs.start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    ifs.load = 0; ifs.load_min_units = 0; ifs.load_sec_tens = 0; ifs.load_sec_units = 0;
    ifs.start = 0; ifs.pause = 0; ifs.clear = 0;
    ifs10.load = 0; ifs10.load_min_units = 0; ifs10.load_sec_tens = 0; ifs10.load_sec_units = 0;
    ifs10.start = 0; ifs10.pause = 0; ifs10.clear = 0;
`ifdef ADD30_EN
    ifs.add30 = 0;
    ifs10.add30 = 0;
`endif

    // Reset
    tick(); tick();
    Reset = 1'b0;
    chk("rst_digits", 32'(d1()), 32'(val(0, 0, 0)));
    chk("rst_running", 32'(ifs.running), 32'd0);
    chk("rst_done", 32'(ifs.done), 32'd0);

    // Full countdown from 1:05
    do_load(1, 0, 5);
    chk("load105", 32'(d1()), 32'(val(1, 0, 5)));
    chk("load105_idle", 32'(ifs.running), 32'd0);
    pulse_start();
    chk("start_running", 32'(ifs.running), 32'd1);
    chk("start_hold", 32'(d1()), 32'(val(1, 0, 5)));
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("count", 32'(d1()), 32'(sec2val(65 - k)));
      chk("count_done0", 32'(ifs.done), 32'd0);
    end
    tick();
    chk("end_digits", 32'(d1()), 32'(val(0, 0, 0)));
    chk("end_done", 32'(ifs.done), 32'd1);
    chk("end_running", 32'(ifs.running), 32'd0);
    tick();
    chk("done_pulse_drop", 32'(ifs.done), 32'd0);
    chk("no_wrap", 32'(d1()), 32'(val(0, 0, 0)));

    // Reset mid-run at 0:40
    do_load(0, 5, 0);
    pulse_start();
    repeat (10) tick();
    chk("pre_rst_040", 32'(d1()), 32'(val(0, 4, 0)));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_digits", 32'(d1()), 32'(val(0, 0, 0)));
    chk("midrst_running", 32'(ifs.running), 32'd0);

    // Pause at 0:42, hold, resume
    do_load(0, 5, 0);
    pulse_start();
    repeat (8) tick();
    chk("at_042", 32'(d1()), 32'(val(0, 4, 2)));
    ifs.pause = 1'b1;
    tick();
    ifs.pause = 1'b0;
    chk("pause_digits", 32'(d1()), 32'(val(0, 4, 2)));
    chk("pause_running", 32'(ifs.running), 32'd0);
    repeat (20) tick();
    chk("pause20_digits", 32'(d1()), 32'(val(0, 4, 2)));
    chk("pause20_running", 32'(ifs.running), 32'd0);
    pulse_start();
    chk("resume_running", 32'(ifs.running), 32'd1);
    chk("resume_hold", 32'(d1()), 32'(val(0, 4, 2)));
    tick();
    chk("resume_dec", 32'(d1()), 32'(val(0, 4, 1)));

    // Load ignored in RUN, honoured in PAUSE
    do_load(2, 0, 0);
    chk("run_load_ignored", 32'(d1()), 32'(val(0, 4, 0)));
    chk("run_load_running", 32'(ifs.running), 32'd1);
    ifs.pause = 1'b1;
    tick();
    ifs.pause = 1'b0;
    do_load(2, 0, 0);
    chk("pause_load", 32'(d1()), 32'(val(2, 0, 0)));
    chk("pause_load_stays", 32'(ifs.running), 32'd0);
    tick();
    chk("pause_load_hold", 32'(d1()), 32'(val(2, 0, 0)));
    pulse_start();
    tick();
    chk("pause_load_resume", 32'(d1()), 32'(val(1, 5, 9)));
    ifs.clear = 1'b1;
    tick();
    ifs.clear = 1'b0;
    do_load(12, 7, 11);
    chk("load_saturate", 32'(d1()), 32'(val(9, 5, 9)));

    // Clear in RUN at 3:17, start at 0:00 ignored
    do_load(3, 1, 8);
    pulse_start();
    tick();
    chk("at_317", 32'(d1()), 32'(val(3, 1, 7)));
    ifs.clear = 1'b1;
    tick();
    ifs.clear = 1'b0;
    chk("clear_digits", 32'(d1()), 32'(val(0, 0, 0)));
    chk("clear_running", 32'(ifs.running), 32'd0);
    chk("clear_no_done", 32'(ifs.done), 32'd0);
    pulse_start();
    chk("start_zero_running", 32'(ifs.running), 32'd0);
    chk("start_zero_digits", 32'(d1()), 32'(val(0, 0, 0)));

    // Start from PAUSE at 0:00 goes IDLE without done
    do_load(0, 0, 3);
    pulse_start();
    ifs.pause = 1'b1;
    tick();
    ifs.pause = 1'b0;
    do_load(0, 0, 0);
    pulse_start();
    chk("pause_zero_running", 32'(ifs.running), 32'd0);
    chk("pause_zero_done", 32'(ifs.done), 32'd0);
    tick();
    chk("pause_zero_done2", 32'(ifs.done), 32'd0);

    // TICK_DIV = 10
    ifs10.load = 1'b1;
    ifs10.load_min_units = 4'd0; ifs10.load_sec_tens = 3'd0; ifs10.load_sec_units = 4'd2;
    tick();
    ifs10.load = 1'b0;
    ifs10.start = 1'b1;
    tick();
    ifs10.start = 1'b0;
    repeat (9) tick();
    chk("div10_before", 32'(d10()), 32'(val(0, 0, 2)));
    tick();
    chk("div10_first", 32'(d10()), 32'(val(0, 0, 1)));
    repeat (9) tick();
    chk("div10_mid", 32'(d10()), 32'(val(0, 0, 1)));
    chk("div10_mid_done", 32'(ifs10.done), 32'd0);
    tick();
    chk("div10_zero", 32'(d10()), 32'(val(0, 0, 0)));
    chk("div10_done", 32'(ifs10.done), 32'd1);
    chk("div10_running", 32'(ifs10.running), 32'd0);

    // Prescaler phase held across pause
    ifs10.load = 1'b1;
    tick();
    ifs10.load = 1'b0;
    ifs10.start = 1'b1;
    tick();
    ifs10.start = 1'b0;
    repeat (4) tick();
    ifs10.pause = 1'b1;
    tick();
    ifs10.pause = 1'b0;
    repeat (5) tick();
    ifs10.start = 1'b1;
    tick();
    ifs10.start = 1'b0;
    repeat (5) tick();
    chk("div10_phase_hold", 32'(d10()), 32'(val(0, 0, 2)));
    tick();
    chk("div10_phase_tick", 32'(d10()), 32'(val(0, 0, 1)));
    ifs10.clear = 1'b1;
    tick();
    ifs10.clear = 1'b0;

`ifdef ADD30_EN
    ifs.add30 = 1'b1;
    tick();
    ifs.add30 = 1'b0;
    chk("add30_idle", 32'(d1()), 32'(val(0, 3, 0)));
    chk("add30_idle_run", 32'(ifs.running), 32'd1);
    ifs.clear = 1'b1;
    tick();
    ifs.clear = 1'b0;
    do_load(9, 4, 6);
    pulse_start();
    tick();
    chk("at_945", 32'(d1()), 32'(val(9, 4, 5)));
    ifs.add30 = 1'b1;
    tick();
    ifs.add30 = 1'b0;
    chk("add30_sat", 32'(d1()), 32'(val(9, 5, 9)));
    chk("add30_sat_run", 32'(ifs.running), 32'd1);
    tick();
    chk("add30_then_dec", 32'(d1()), 32'(val(9, 5, 8)));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
